// File: rtl/usb_raw_replay.sv
// usb_raw_replay: buffers packed raw D+/D- samples in a FIFO and replays them
// on clk_48m at a rate set by a fractional NCO. Used to drive the usb core's
// pad inputs in simulation and in on-FPGA self-test builds.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | outputs idle, FIFO accepts preload, waiting for start
// PRIME  | waiting for half-full FIFO or a queued last word
// RUN    | NCO ticking, one sample played per carry
// DONE   | final sample played, outputs idle, done=1
module usb_raw_replay #(
  parameter int DW        = 8,
  parameter int FIFO_LOG2 = 4,
  parameter int NCO_W     = 16,
  parameter int IDLE_J    = 0
) (
  input  logic                 clk_48m,
  input  logic                 rst,
  input  logic [DW-1:0]        in_data,
  input  logic                 in_last,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 start,
  input  logic [NCO_W-1:0]     nco_inc,
  output logic                 out_dp,
  output logic                 out_dn,
  output logic                 out_stb,
  output logic                 busy,
  output logic                 done,
  output logic                 underflow,
  output logic [FIFO_LOG2:0]   level
);

  localparam int DEPTH = 1 << FIFO_LOG2;
  localparam int NS    = DW / 2;
  localparam int IW    = (NS > 1) ? $clog2(NS) : 1;

  localparam logic [FIFO_LOG2:0] DEPTH_L = (FIFO_LOG2+1)'(DEPTH);
  localparam logic [FIFO_LOG2:0] HALF_L  = (FIFO_LOG2+1)'(DEPTH / 2);
  localparam logic [FIFO_LOG2:0] LV_ONE  = (FIFO_LOG2+1)'(1);
  localparam logic [FIFO_LOG2-1:0] PTR_ONE = FIFO_LOG2'(1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NS - 1);
  localparam logic [IW-1:0] IDX_ONE  = IW'(1);
  localparam logic IDLE_DP = (IDLE_J != 0);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PRIME = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]           state;
  logic [DW:0]          mem [DEPTH];
  logic [FIFO_LOG2-1:0] wr_ptr;
  logic [FIFO_LOG2-1:0] rd_ptr;
  logic [FIFO_LOG2:0]   last_cnt;
  logic [NCO_W-1:0]     acc;
  logic [DW-1:0]        cur_data;
  logic [IW-1:0]        cur_idx;
  logic                 cur_valid;
  logic                 cur_last;
  logic                 end_pending;

  logic                 push;
  logic                 pop;
  logic                 tick;
  logic                 fifo_empty;
  logic [NCO_W:0]       sum;
  logic [DW:0]          rd_word;
  logic [1:0]           cur_smp;

  assign in_ready   = (level < DEPTH_L);
  assign push       = in_valid & in_ready;
  assign fifo_empty = (level == '0);
  assign sum        = {1'b0, acc} + {1'b0, nco_inc};
  assign tick       = (state == ST_RUN) & sum[NCO_W];
  assign rd_word    = mem[rd_ptr];
  assign cur_smp    = cur_data[{cur_idx, 1'b0} +: 2];
  assign busy       = (state == ST_PRIME) | (state == ST_RUN);
  // a word is only popped when the current one is exhausted and no end is pending
  assign pop        = tick & ~cur_valid & ~end_pending & ~fifo_empty;

  // FIFO storage; the last flag travels with each word
  always_ff @(posedge clk_48m) begin
    if (push) mem[wr_ptr] <= {in_last, in_data};
  end

  // FIFO pointers, occupancy and count of queued last-flagged words
  always_ff @(posedge clk_48m) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      last_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   level <= level + LV_ONE;
        2'b01:   level <= level - LV_ONE;
        default: level <= level;
      endcase
      case ({push & in_last, pop & rd_word[DW]})
        2'b10:   last_cnt <= last_cnt + LV_ONE;
        2'b01:   last_cnt <= last_cnt - LV_ONE;
        default: last_cnt <= last_cnt;
      endcase
    end
  end

  // sequencing FSM, NCO and registered sample output
  always_ff @(posedge clk_48m) begin
    if (rst) begin
      state       <= ST_IDLE;
      acc         <= '0;
      cur_data    <= '0;
      cur_idx     <= '0;
      cur_valid   <= 1'b0;
      cur_last    <= 1'b0;
      end_pending <= 1'b0;
      out_dp      <= IDLE_DP;
      out_dn      <= 1'b0;
      out_stb     <= 1'b0;
      done        <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      out_stb <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state       <= ST_PRIME;
            done        <= 1'b0;
            underflow   <= 1'b0;
            cur_valid   <= 1'b0;
            cur_idx     <= '0;
            end_pending <= 1'b0;
          end
        end
        ST_PRIME: begin
          if ((level >= HALF_L) || (last_cnt != '0)) begin
            state <= ST_RUN;
            acc   <= '0;
          end
        end
        ST_RUN: begin
          acc <= sum[NCO_W-1:0];
          if (tick) begin
            out_stb <= 1'b1;
            if (cur_valid) begin
              {out_dp, out_dn} <= cur_smp;
              if (cur_idx == LAST_IDX) begin
                cur_valid   <= 1'b0;
                end_pending <= cur_last;
              end else begin
                cur_idx <= cur_idx + IDX_ONE;
              end
            end else if (end_pending) begin
              {out_dp, out_dn} <= {IDLE_DP, 1'b0};
              end_pending      <= 1'b0;
              done             <= 1'b1;
              state            <= ST_DONE;
            end else if (!fifo_empty) begin
              {out_dp, out_dn} <= rd_word[1:0];
              cur_data         <= rd_word[DW-1:0];
              cur_last         <= rd_word[DW];
              cur_idx          <= IDX_ONE;
              cur_valid        <= (NS > 1);
              end_pending      <= (NS == 1) & rd_word[DW];
            end else begin
              // starved: hold the line idle and flag it, but keep running
              {out_dp, out_dn} <= {IDLE_DP, 1'b0};
              underflow        <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usb_raw_replay.sv
// Directed bench for usb_raw_replay: main instance with defaults (DW=8, SE0 idle)
// and a second DW=4 instance with J idle.
module tb_usb_raw_replay;

  logic        clk_48m = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_last, in_valid, in_ready, start;
  logic [15:0] nco_inc;
  logic        out_dp, out_dn, out_stb, busy, done, underflow;
  logic [4:0]  level;

  logic [3:0]  j_in_data;
  logic        j_in_last, j_in_valid, j_in_ready, j_start;
  logic [15:0] j_nco_inc;
  logic        j_dp, j_dn, j_stb, j_busy, j_done, j_underflow;
  logic [4:0]  j_level;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  always #10 clk_48m = ~clk_48m;
  always @(posedge clk_48m) cyc <= cyc + 1;

  usb_raw_replay u_dut (
    .clk_48m(clk_48m), .rst(rst), .in_data(in_data), .in_last(in_last),
    .in_valid(in_valid), .in_ready(in_ready), .start(start), .nco_inc(nco_inc),
    .out_dp(out_dp), .out_dn(out_dn), .out_stb(out_stb), .busy(busy),
    .done(done), .underflow(underflow), .level(level)
  );

  usb_raw_replay #(.DW(4), .IDLE_J(1)) u_dut_j (
    .clk_48m(clk_48m), .rst(rst), .in_data(j_in_data), .in_last(j_in_last),
    .in_valid(j_in_valid), .in_ready(j_in_ready), .start(j_start), .nco_inc(j_nco_inc),
    .out_dp(j_dp), .out_dn(j_dn), .out_stb(j_stb), .busy(j_busy),
    .done(j_done), .underflow(j_underflow), .level(j_level)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // every sample of these words is non-zero, so a 00 on the line is always idle
  function automatic logic [7:0] pat(input int i);
    logic [7:0] w;
    for (int k = 0; k < 4; k++) w[2*k +: 2] = 2'(((i + k) % 3) + 1);
    return w;
  endfunction

  task automatic pulse_start();
    @(posedge clk_48m); #1 start = 1'b1;
    @(posedge clk_48m); #1 start = 1'b0;
  endtask

  task automatic push_word(input logic [7:0] d, input logic l, input int budget, output bit ok);
    in_data = d; in_last = l; in_valid = 1'b1; ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk_48m);
      if (in_ready) begin
        @(posedge clk_48m); #1;
        ok = 1'b1;
        break;
      end
    end
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic feed(input int base, input int n, input bit last_final, output int n_lost);
    bit ok;
    n_lost = 0;
    for (int i = 0; i < n; i++) begin
      push_word(pat(base + i), last_final && (i == n - 1), 2000, ok);
      if (!ok) n_lost++;
    end
  endtask

  task automatic wait_stb(input int budget, output logic [1:0] v, output int t, output bit ok);
    ok = 1'b0; v = 2'b00; t = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk_48m);
      if (out_stb) begin
        v = {out_dp, out_dn}; t = cyc; ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic collect(input int base, input int budget, output int n, output int err,
                         output int idle, output int win_cnt, output int gmin,
                         output int gmax, output bit fin);
    int t0, tp;
    logic [7:0] w;
    n = 0; err = 0; idle = 0; win_cnt = 0; gmin = 1000000; gmax = 0; fin = 1'b0;
    t0 = -1; tp = -1;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk_48m);
      if (out_stb) begin
        if ({out_dp, out_dn} == 2'b00) idle++;
        else begin
          w = pat(base + n / 4);
          if ({out_dp, out_dn} != w[2*(n % 4) +: 2]) err++;
          if (t0 < 0) t0 = cyc;
          if (cyc - t0 < 3000) win_cnt++;
          if (tp >= 0) begin
            if (cyc - tp < gmin) gmin = cyc - tp;
            if (cyc - tp > gmax) gmax = cyc - tp;
          end
          tp = cyc;
          n++;
        end
      end
      if (done) begin
        fin = 1'b1;
        break;
      end
    end
  endtask

  logic [1:0] exp1 [16] = '{2'b11, 2'b10, 2'b01, 2'b00, 2'b00, 2'b01, 2'b10, 2'b11,
                            2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b11, 2'b11, 2'b11};
  logic [1:0] expj [3]  = '{2'b10, 2'b01, 2'b10};
  logic [7:0] words1 [4] = '{8'h1B, 8'hE4, 8'h00, 8'hFF};

  initial begin
    logic [1:0] v;
    int t, tprev, n, err, idle, win, gmin, gmax, lost, stbs;
    bit ok, fin, uf_seen, found;

    rst = 1'b1; in_data = '0; in_last = 1'b0; in_valid = 1'b0; start = 1'b0;
    nco_inc = 16'h8000;
    j_in_data = '0; j_in_last = 1'b0; j_in_valid = 1'b0; j_start = 1'b0;
    j_nco_inc = 16'h8000;
    repeat (3) @(posedge clk_48m);
    @(negedge clk_48m);
    chk("rst_dpdn",      {out_dp, out_dn}, 2'b00);
    chk("rst_stb",       out_stb, 1'b0);
    chk("rst_done",      done, 1'b0);
    chk("rst_uf",        underflow, 1'b0);
    chk("rst_busy",      busy, 1'b0);
    chk("rst_level",     level, 5'd0);
    chk("rst_ready",     in_ready, 1'b1);
    chk("rst_j_dpdn",    {j_dp, j_dn}, 2'b10);
    @(posedge clk_48m); #1 rst = 1'b0;

    // basic playback, two cycles per sample
    for (int i = 0; i < 4; i++) push_word(words1[i], i == 3, 50, ok);
    @(negedge clk_48m);
    chk("t1_level", level, 5'd4);
    pulse_start();
    tprev = 0;
    for (int i = 0; i < 16; i++) begin
      wait_stb(40, v, t, ok);
      chk($sformatf("t1_stb_seen_%0d", i), ok, 1'b1);
      chk($sformatf("t1_smp_%0d", i), v, exp1[i]);
      if (i > 0) chk($sformatf("t1_gap_%0d", i), t - tprev, 2);
      tprev = t;
    end
    chk("t1_busy", busy, 1'b1);
    @(negedge clk_48m);
    chk("t1_done_early", done, 1'b0);
    @(negedge clk_48m);
    chk("t1_done", done, 1'b1);
    chk("t1_end_stb", out_stb, 1'b1);
    chk("t1_end_idle", {out_dp, out_dn}, 2'b00);
    chk("t1_uf", underflow, 1'b0);

    // ~4 MHz rate with a continuously fed loader
    nco_inc = 16'h1555;
    pulse_start();
    fork
      feed(0, 70, 1'b1, lost);
      collect(0, 6000, n, err, idle, win, gmin, gmax, fin);
    join
    chk("t2_lost", lost, 0);
    chk("t2_done", fin, 1'b1);
    chk("t2_n", n, 280);
    chk("t2_data_err", err, 0);
    chk("t2_idle", idle, 1);
    chk($sformatf("t2_rate cnt=%0d", win), (win >= 248) && (win <= 252), 1'b1);
    chk($sformatf("t2_gap min=%0d max=%0d", gmin, gmax), (gmin >= 11) && (gmax <= 13), 1'b1);
    chk("t2_uf", underflow, 1'b0);

    // starve the loader mid-run
    nco_inc = 16'h8000;
    pulse_start();
    uf_seen = 1'b0;
    fork
      begin
        int l1, l2;
        feed(100, 10, 1'b0, l1);
        for (int c = 0; c < 1000; c++) begin
          @(negedge clk_48m);
          if (underflow) begin uf_seen = 1'b1; break; end
        end
        repeat (40) @(posedge clk_48m);
        #1 feed(110, 6, 1'b1, l2);
        lost = l1 + l2;
      end
      collect(100, 3000, n, err, idle, win, gmin, gmax, fin);
    join
    chk("t3_uf_seen", uf_seen, 1'b1);
    chk("t3_lost", lost, 0);
    chk("t3_done", fin, 1'b1);
    chk("t3_n", n, 64);
    chk("t3_data_err", err, 0);
    chk($sformatf("t3_idle cnt=%0d", idle), idle >= 20, 1'b1);
    chk("t3_uf_sticky", underflow, 1'b1);

    // fill the FIFO while in DONE, then pop and refill
    for (int i = 0; i < 16; i++) push_word(pat(200 + i), 1'b0, 50, ok);
    @(negedge clk_48m);
    chk("t4_level_full", level, 5'd16);
    chk("t4_ready_full", in_ready, 1'b0);
    in_data = 8'hAA; in_valid = 1'b1;
    repeat (3) @(negedge clk_48m);
    chk("t4_extra_rejected", level, 5'd16);
    pulse_start();
    found = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk_48m);
      if (level == 5'd15) begin found = 1'b1; break; end
    end
    chk("t4_popped", found, 1'b1);
    @(negedge clk_48m);
    chk("t4_refilled", level, 5'd16);
    #1 in_valid = 1'b0;

    // reset in the middle of RUN
    found = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk_48m);
      if (level == 5'd7) begin found = 1'b1; break; end
    end
    chk("t5_level7", found, 1'b1);
    chk("t5_busy_pre", busy, 1'b1);
    rst = 1'b1;
    @(negedge clk_48m);
    chk("t5_level", level, 5'd0);
    chk("t5_dpdn", {out_dp, out_dn}, 2'b00);
    chk("t5_busy", busy, 1'b0);
    chk("t5_stb", out_stb, 1'b0);
    @(posedge clk_48m); #1 rst = 1'b0;
    pulse_start();
    stbs = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk_48m);
      if (out_stb) stbs++;
    end
    chk("t5_prime_busy", busy, 1'b1);
    chk("t5_prime_nostb", stbs, 0);
    chk("t5_prime_done", done, 1'b0);

    // DW=4 instance with J idle
    @(posedge clk_48m); #1 j_in_data = 4'h6; j_in_last = 1'b1; j_in_valid = 1'b1;
    @(posedge clk_48m); #1 j_in_valid = 1'b0; j_in_last = 1'b0;
    @(posedge clk_48m); #1 j_start = 1'b1;
    @(posedge clk_48m); #1 j_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ok = 1'b0;
      for (int c = 0; c < 40; c++) begin
        @(negedge clk_48m);
        if (j_stb) begin ok = 1'b1; break; end
      end
      chk($sformatf("t6_stb_seen_%0d", i), ok, 1'b1);
      chk($sformatf("t6_smp_%0d", i), {j_dp, j_dn}, expj[i]);
    end
    chk("t6_done", j_done, 1'b1);
    @(posedge clk_48m); #1 j_start = 1'b1;
    @(posedge clk_48m); #1 j_start = 1'b0;
    stbs = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk_48m);
      if (j_stb) stbs++;
    end
    chk("t6_prime_busy", j_busy, 1'b1);
    chk("t6_prime_done", j_done, 1'b0);
    chk("t6_prime_nostb", stbs, 0);
    chk("t6_idle_j", {j_dp, j_dn}, 2'b10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/usb_raw_replay.md
# usb_raw_replay

Parametrised replay engine for raw USB line captures: accepts packed 2-bit D+/D- samples from a loader (file reader, memory, or host bridge), buffers them in a FIFO and re-emits them on `clk_48m` at a programmable sample rate set by a fractional NCO. It drives the `pad_dp`/`pad_dn` inputs of the `usb` core in simulation and in on-FPGA self-test builds. Unlike the previous fixed-rate, one-sample-per-byte replay, it supports configurable packing width, rate, idle line state, priming, and end-of-capture and underflow reporting.

## Interface
Parameters
- `DW`, 8: input word width; must be even and ≥2; holds `DW/2` samples.
- `FIFO_LOG2`, 4: FIFO depth is `2**FIFO_LOG2` words.
- `NCO_W`, 16: NCO accumulator width.
- `IDLE_J`, 0: idle output; 0 gives dp=0, dn=0 (SE0), 1 gives dp=1, dn=0 (full-speed J).

Ports
- `clk_48m`  in  1  clock; all logic is in this domain.
- `rst`  in  1  reset: synchronous, active-high; clock `clk_48m`.
- `in_data`  in  DW  packed samples; sample k is at bits [2k+1:2k], with dp=bit 2k+1 and dn=bit 2k; k=0 is played first.
- `in_last`  in  1  marks the final word of the capture; qualified by the in_valid&in_ready handshake.
- `in_valid`  in  1  loader word valid.
- `in_ready`  out  1  FIFO can accept a word.
- `start`  in  1  single-cycle pulse that starts or restarts playback.
- `nco_inc`  in  NCO_W  phase increment; sample rate = 48 MHz·nco_inc/2^NCO_W. Sampled every cycle.
- `out_dp`, `out_dn`  out  1 each  replayed line state.
- `out_stb`  out  1  high for one cycle when a new sample appears on out_dp/out_dn.
- `busy`  out  1  state is PRIME or RUN.
- `done`  out  1  final sample has been played.
- `underflow`  out  1  sticky; a sample tick found no data.
- `level`  out  FIFO_LOG2+1  FIFO occupancy in words.

## Operation
- States: IDLE, PRIME, RUN, DONE.
- IDLE: the FIFO accepts words (preload allowed) and the outputs hold the idle value. `start` moves to PRIME.
- PRIME: wait until `level` ≥ 2**(FIFO_LOG2-1) or a word with `in_last` sits in the FIFO, then go to RUN. The NCO accumulator is cleared on entry to RUN.
- RUN, each cycle: `{carry, acc} <= acc + nco_inc`. Carry=1 is a tick.
  - On a tick, play the next sample of the current word.
  - If no samples remain in the current word, pop the FIFO and play sample 0 of the popped word.
  - A tick with the FIFO empty, no current word and no `in_last` yet seen: output the idle value, set `underflow`, stay in RUN. No sample is skipped; playback resumes with the next pushed word.
  - After the tick that plays the last sample of the `in_last` word, the next tick drives the idle value, pulses `out_stb` and enters DONE.
- DONE: `done`=1 and the outputs hold idle. Words arriving in DONE are accepted and queued. `start` clears `done` and `underflow` and goes to PRIME.
- `start` in PRIME or RUN is ignored.
- `nco_inc`=0 means no ticks: the block holds the current sample indefinitely with no error.
- `nco_inc` ≥ 2^(NCO_W-1) gives at most one tick per cycle. The all-ones increment ticks on every cycle except the first.

## Timing
- Reset values: out_dp/out_dn = idle value, out_stb=0, done=0, underflow=0, busy=0, level=0, in_ready=1. State is IDLE; FIFO, accumulator and sample index are cleared.
- `rst` asserted mid-playback aborts immediately on the next edge and discards all buffered words.
- `in_ready` = (level < 2**FIFO_LOG2), computed from registered level. A push in the same cycle as a pop on a full FIFO is not accepted.
- Simultaneous push and pop leave `level` unchanged. `level` updates one cycle after the handshake.
- Latency: the tick (carry) occurs in cycle N; out_dp, out_dn and out_stb are registered and show the new sample in cycle N+1.
- A pushed word is available for pop one cycle after its handshake; first-word-fall-through is not required.
- `in_last` is latched per FIFO entry. Words pushed after the last word are kept for the next `start`.

## Test plan
- DW=8, nco_inc=0x8000, preload 4 words 0x1B,0xE4,0x00,0xFF (last on 0xFF), start: dp/dn sequence 11,10,01,00, then 00,01,10,11, then 00×4, then 11×4. Each sample lasts 2 cycles. done asserts 2 cycles after the final sample; underflow=0.
- nco_inc=0x1555 (≈4 MHz): out_stb spacing alternates 12/12/12… ±1 cycle. Average over 3000 cycles is 12.0±0.1.
- Starve the loader mid-RUN for 20 ticks: outputs go idle, underflow=1 and stays set. Resumed words play in order with none lost; done still reached.
- Fill the FIFO to 16 words with in_valid held high: in_ready=0 and level=16. An extra word offered while full is not accepted. Pop then push restores level=16.
- Assert rst during RUN with level=7: next cycle level=0, outputs idle, busy=0. A new start without words stays in PRIME forever.
- IDLE_J=1, DW=4, in_last on a single word 0x6: samples 10,01, then J (dp=1,dn=0). done=1; a second start with no data stays in PRIME.
